// File: rtl/fetch_queue.sv
// Instruction fetch unit: PC sequencer feeding a DEPTH-entry {PC, INSTR} queue.
// Latency: issue to OUT_VALID is 2 cycles, or 1 cycle with FETCH_BYPASS_EN (empty-queue bypass).
// Backpressure: OUT_READY stalls the head; IREQ is withheld until a slot is reserved for the response.
module fetch_queue #(
  parameter int AW = 30,
  parameter int DW = 32,
  parameter int DEPTH = 4,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          CLK,
  input  logic          RSTN,
  output logic          IREQ,
  output logic [AW-1:0] IADDR,
  input  logic [DW-1:0] INSTR,
  input  logic          REDIR_VALID,
  input  logic [AW-1:0] REDIR_ADDR,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic [DW-1:0] OUT_INSTR,
  output logic [AW-1:0] OUT_PC
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = CW + 1;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] instr;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] pc;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          inflight;

  logic [OW-1:0] occ;
  logic          fetch_req;
  logic          push;
  logic          pop;
  logic          q_empty;
  logic          out_vld;
  logic          wr_en;
  logic          rd_adv;
  entry_t        resp;
  entry_t        head;

  // Occupancy counts the outstanding response so every push has a slot.
  assign occ       = OW'(count) + OW'(inflight);
  assign fetch_req = RSTN & ~REDIR_VALID & (occ < OW'(DEPTH));
  assign push      = inflight & ~REDIR_VALID;
  assign q_empty   = (count == '0);

  // The response belongs to the previous request, which is always pc-1 while inflight.
  assign resp.pc    = pc - AW'(1);
  assign resp.instr = INSTR;

`ifdef FETCH_BYPASS_EN
  assign out_vld = ~REDIR_VALID & (~q_empty | push);
  assign head    = q_empty ? resp : mem[rd_ptr];
  assign pop     = out_vld & OUT_READY;
  assign wr_en   = push & ~(q_empty & OUT_READY);
  assign rd_adv  = pop & ~q_empty;
`else
  assign out_vld = ~REDIR_VALID & ~q_empty;
  assign head    = mem[rd_ptr];
  assign pop     = out_vld & OUT_READY;
  assign wr_en   = push;
  assign rd_adv  = pop;
`endif

  assign IREQ      = fetch_req;
  assign IADDR     = pc;
  assign OUT_VALID = out_vld;
  assign OUT_INSTR = out_vld ? head.instr : '0;
  assign OUT_PC    = out_vld ? head.pc : '0;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      pc       <= RESET_PC;
      inflight <= 1'b0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else if (REDIR_VALID) begin
      pc       <= REDIR_ADDR;
      inflight <= 1'b0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      inflight <= fetch_req;
      if (fetch_req) pc <= pc + AW'(1);
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (rd_adv) rd_ptr <= rd_ptr + PW'(1);
      if (wr_en && !rd_adv) count <= count + CW'(1);
      else if (!wr_en && rd_adv) count <= count - CW'(1);
    end
  end

  // Storage needs no reset: outputs are gated by out_vld.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_ptr] <= resp;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboarded bench for fetch_queue: a memory model answers every IREQ with addr+0x100.
module tb_fetch_queue;
  localparam int AW = 30;
  localparam int DW = 32;
`ifdef FETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] instr;
  } exp_t;

  logic          CLK = 1'b0;
  logic          RSTN = 1'b0;
  logic          IREQ;
  logic [AW-1:0] IADDR;
  logic [DW-1:0] INSTR = 32'hDEADBEEF;
  logic          REDIR_VALID = 1'b0;
  logic [AW-1:0] REDIR_ADDR = '0;
  logic          OUT_VALID;
  logic          OUT_READY = 1'b0;
  logic [DW-1:0] OUT_INSTR;
  logic [AW-1:0] OUT_PC;

  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];

  logic          mem_req = 1'b0;
  logic [AW-1:0] mem_addr = '0;

  fetch_queue #(.AW(AW), .DW(DW), .DEPTH(4), .RESET_PC('0)) dut (
    .CLK(CLK), .RSTN(RSTN), .IREQ(IREQ), .IADDR(IADDR), .INSTR(INSTR),
    .REDIR_VALID(REDIR_VALID), .REDIR_ADDR(REDIR_ADDR), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .OUT_INSTR(OUT_INSTR), .OUT_PC(OUT_PC)
  );

  always #5 CLK = ~CLK;

  // Memory: responds one cycle after a request.
  always @(negedge CLK) begin
    mem_req  = IREQ;
    mem_addr = IADDR;
  end
  always @(posedge CLK) begin
    #1;
    INSTR = mem_req ? ({2'b00, mem_addr} + 32'h100) : 32'hDEADBEEF;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", nm, got, want, $time);
    end
  endtask

  // Monitor: every accepted head must match the oldest expectation.
  always @(negedge CLK) begin
    if (RSTN && OUT_VALID && OUT_READY) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pop got_pc=%h want=none at %0t", OUT_PC, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_pc", {2'b00, OUT_PC}, {2'b00, e.pc});
        chk("sb_instr", OUT_INSTR, e.instr);
      end
    end
  end

  task automatic expect_entry(input logic [AW-1:0] a);
    exp_t e;
    e.pc    = a;
    e.instr = {2'b00, a} + 32'h100;
    exp_q.push_back(e);
  endtask

  // All tasks start and end just after a rising edge.
  task automatic do_reset();
    RSTN = 1'b0;
    REDIR_VALID = 1'b0;
    @(negedge CLK);
    chk("rst_ireq", IREQ, 0);
    chk("rst_oval", OUT_VALID, 0);
    chk("rst_opc", OUT_PC, 0);
    chk("rst_oinstr", OUT_INSTR, 0);
    @(posedge CLK); #1;
    RSTN = 1'b1;
    exp_q.delete();
  endtask

  task automatic stream(input logic [AW-1:0] first, input int n);
    logic [AW-1:0] a;
    REDIR_VALID = 1'b0;
    OUT_READY = 1'b1;
    for (int i = 0; i < n; i++) begin
      a = first + AW'(i);
      @(negedge CLK);
      chk("str_ireq", IREQ, 1);
      chk("str_iaddr", IADDR, a);
      chk("str_oval", OUT_VALID, (i >= LAT) ? 1 : 0);
      if (i + LAT < n) expect_entry(a);
      @(posedge CLK); #1;
    end
  endtask

  task automatic redirect(input logic [AW-1:0] a);
    REDIR_VALID = 1'b1;
    REDIR_ADDR = a;
    @(negedge CLK);
    chk("redir_ireq", IREQ, 0);
    chk("redir_oval", OUT_VALID, 0);
    chk("redir_drain", exp_q.size(), 0);
    @(posedge CLK); #1;
    REDIR_VALID = 1'b0;
  endtask

  // Reset asserted mid-cycle, held across one rising edge.
  task automatic mid_reset(input logic want_ireq);
    OUT_READY = 1'b0;
    @(negedge CLK);
    chk("mr_pre_oval", OUT_VALID, 1);
    chk("mr_pre_ireq", IREQ, want_ireq);
    chk("mr_drain", exp_q.size(), 0);
    #1 RSTN = 1'b0;
    #1;
    chk("mr_oval", OUT_VALID, 0);
    chk("mr_ireq", IREQ, 0);
    chk("mr_opc", OUT_PC, 0);
    @(posedge CLK); #1;
    RSTN = 1'b1;
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    // Streaming from reset.
    OUT_READY = 1'b1;
    do_reset();
    stream('0, 8);

    // Fill with consumer stalled, then release.
    OUT_READY = 1'b0;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      chk("fill_ireq", IREQ, 1);
      chk("fill_iaddr", IADDR, k);
      expect_entry(AW'(k));
      @(posedge CLK); #1;
    end
    for (int k = 4; k < 6; k++) begin
      @(negedge CLK);
      chk("full_ireq", IREQ, 0);
      chk("full_oval", OUT_VALID, 1);
      @(posedge CLK); #1;
    end
    OUT_READY = 1'b1;
    @(negedge CLK);
    chk("pop_no_credit_ireq", IREQ, 0);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("resume_ireq", IREQ, 1);
    chk("resume_iaddr", IADDR, 4);
    @(posedge CLK); #1;
    repeat (2) begin
      @(posedge CLK); #1;
    end
    OUT_READY = 1'b0;
    @(negedge CLK);
    chk("fill_drain", exp_q.size(), 0);
    chk("fill_next_pc", OUT_PC, 4);
    @(posedge CLK); #1;

    // Redirects, back-to-back redirects and PC wrap.
    OUT_READY = 1'b1;
    do_reset();
    stream('0, 5);
    redirect(30'h40);
    stream(30'h40, 4);
    redirect(30'h100);
    redirect(30'h3FFFFFFF);
    stream(30'h3FFFFFFF, 4);

    // Reset with three queued entries, then reset with a response in flight.
    OUT_READY = 1'b0;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      chk("mr_fill_iaddr", IADDR, k);
      @(posedge CLK); #1;
    end
    mid_reset(1'b0);
    stream('0, 4);
    mid_reset(1'b1);
    stream('0, 5);

    OUT_READY = 1'b0;
    @(negedge CLK);
    chk("final_drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
